fifo_rd_drain: RTL and testbench

Read-side consumer for the team's 8-entry async FIFO. Lives entirely in the read clock domain. Pops words from the FIFO read port (first-word-fall-through: data is valid whenever empty is low) into a 2-entry output buffer. Presents them downstream as a valid/ready stream with frame delimiting and statistics counters.

---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/fifo_skid_buf.sv | 56 +++++
 rtl/fifo_rd_drain.sv | 79 +++++++
 tb/tb_fifo_rd_drain.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared defaults and sizing helpers for the async-FIFO read-side drain.
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Frame position needs at least one bit even for single-beat frames.
  function automatic int pos_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer: head register drives the output, tail absorbs one extra word.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              accept,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] head_p1;
  logic [DATA_W-1:0] tail_p1;
  logic [1:0]        occ_p1;

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      occ_p1  <= 2'd0;
      head_p1 <= '0;
      tail_p1 <= '0;
    end else if (flush) begin
      occ_p1 <= 2'd0;
    end else begin
      case ({push, accept})
        2'b10: begin
          if (occ_p1 == 2'd0) head_p1 <= push_data;
          else                tail_p1 <= push_data;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          head_p1 <= tail_p1;
          occ_p1  <= occ_p1 - 2'd1;
        end
        2'b11: begin
          // Single occupant leaves as the new word arrives: new word goes straight to head.
          if (occ_p1 == 2'd1) begin
            head_p1 <= push_data;
          end else begin
            head_p1 <= tail_p1;
            tail_p1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = head_p1;
  assign occ       = occ_p1;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain FIFO consumer: pops into a 2-entry buffer, streams out framed beats with stats.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int               POS_W    = pos_w(FRAME_LEN);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  logic [1:0]       occ;
  logic             push;
  logic             accept;
  logic [POS_W-1:0] pos_p1;
  logic [POS_W-1:0] pos_nxt;
  logic             last_p1;

  // Pop decision depends only on registered occupancy, never on out_ready.
  assign push       = rst_n & ~flush & ~fifo_empty & (occ < 2'd2);
  assign fifo_rd_en = push;
  assign out_valid  = (occ != 2'd0);
  assign accept     = out_valid & out_ready;

  fifo_skid_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_dout),
    .accept    (accept),
    .head_data (out_data),
    .occ       (occ)
  );

  always_comb begin
    pos_nxt = pos_p1;
    if (flush)       pos_nxt = '0;
    else if (accept) pos_nxt = (pos_p1 == LAST_POS) ? '0 : pos_p1 + POS_W'(1);
  end

  // Frame position and statistics stage
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      pos_p1    <= '0;
      last_p1   <= 1'b0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      pos_p1    <= pos_nxt;
      last_p1   <= (pos_nxt == LAST_POS);
      beat_cnt  <= beat_cnt + CNT_W'(accept);
      stall_cnt <= sat_inc(stall_cnt, out_valid & ~out_ready);
    end
  end

  assign out_last = last_p1;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: FIFO source model, expected-beat scoreboard, counter checks.
module tb_fifo_rd_drain;

  logic       rd_clk = 1'b0;
  logic       rst_n;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [3:0] beat_cnt;
  logic [3:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int pop_count = 0;
  int pc_snap;

  logic [7:0] src_q[$];
  logic [8:0] exp_q[$];

  always #5 rd_clk = ~rd_clk;

  fifo_rd_drain #(.DATA_W(8), .FRAME_LEN(4), .CNT_W(4)) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .beat_cnt   (beat_cnt),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (src_q.size() == 0);
    fifo_dout  = fifo_empty ? 8'h00 : src_q[0];
  endtask

  task automatic add_word(input logic [7:0] d);
    src_q.push_back(d);
    refresh();
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rd_clk);
    #2;
  endtask

  // FIFO read-port model: advance the head after an edge that popped it.
  always @(posedge rd_clk) begin
    logic popped;
    popped = fifo_rd_en && !fifo_empty;
    #1;
    if (popped) begin
      void'(src_q.pop_front());
      pop_count++;
    end
    refresh();
  end

  // Scoreboard monitor: every beat that will be accepted at the next edge.
  always @(negedge rd_clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected actual=%0h required=none t=%0t", out_data, $time);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("beat_data", 32'(out_data), 32'(e[7:0]));
        chk("beat_last", 32'(out_last), 32'(e[8]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    refresh();
    add_word(8'hAA);

    // Reset held with data waiting: nothing may be popped.
    #2;
    chk("rst_rd_en_pre", 32'(fifo_rd_en), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
    end
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_beat", 32'(beat_cnt), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_pops", pop_count, 0);
    src_q.delete();
    refresh();
    rst_n = 1'b1;

    // Streaming 0x01..0x08 at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      add_word(8'(i));
      expect_beat(8'(i), (i == 4) || (i == 8));
    end
    step(1);
    chk("stream_first_valid", 32'(out_valid), 1);
    chk("stream_first_data", 32'(out_data), 32'h01);
    step(10);
    chk("stream_beat", 32'(beat_cnt), 8);
    chk("stream_idle_valid", 32'(out_valid), 0);

    // Backpressure: two words buffered, third stays in the FIFO.
    out_ready = 1'b0;
    pop_count = 0;
    add_word(8'h10); add_word(8'h11); add_word(8'h12);
    expect_beat(8'h10, 0); expect_beat(8'h11, 0); expect_beat(8'h12, 0);
    step(2);
    chk("bp_stall_1", 32'(stall_cnt), 1);
    step(3);
    chk("bp_pops", pop_count, 2);
    chk("bp_rd_en", 32'(fifo_rd_en), 0);
    chk("bp_hold_data", 32'(out_data), 32'h10);
    chk("bp_stall_4", 32'(stall_cnt), 4);
    out_ready = 1'b1;
    step(5);
    chk("bp_beat", 32'(beat_cnt), 11);
    chk("bp_stall_hold", 32'(stall_cnt), 4);

    // Bring frame position to 2 (0x13 closes the previous frame).
    add_word(8'h13); add_word(8'h20); add_word(8'h21);
    expect_beat(8'h13, 1); expect_beat(8'h20, 0); expect_beat(8'h21, 0);
    step(6);
    chk("pre_flush_beat", 32'(beat_cnt), 14);

    // Flush with two buffered words.
    out_ready = 1'b0;
    add_word(8'h30); add_word(8'h31); add_word(8'h32);
    step(2);
    chk("pre_flush_data", 32'(out_data), 32'h30);
    pc_snap = pop_count;
    flush = 1'b1;
    chk("flush_rd_en", 32'(fifo_rd_en), 0);
    step(1);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_no_pop", pop_count, pc_snap);
    chk("flush_stall", 32'(stall_cnt), 6);
    chk("flush_beat_kept", 32'(beat_cnt), 14);
    flush = 1'b0;
    out_ready = 1'b1;
    add_word(8'h40); add_word(8'h41); add_word(8'h42);
    expect_beat(8'h32, 0); expect_beat(8'h40, 0); expect_beat(8'h41, 0); expect_beat(8'h42, 1);
    step(1);
    chk("post_flush_data", 32'(out_data), 32'h32);
    chk("post_flush_last", 32'(out_last), 0);
    step(1);
    chk("beat_cnt_15", 32'(beat_cnt), 15);
    step(1);
    chk("beat_cnt_wrap", 32'(beat_cnt), 0);
    step(5);
    chk("post_flush_beat", 32'(beat_cnt), 2);

    // Reset mid-stream with one word buffered at frame position 3.
    add_word(8'h50); add_word(8'h51); add_word(8'h52);
    expect_beat(8'h50, 0); expect_beat(8'h51, 0); expect_beat(8'h52, 0);
    step(6);
    out_ready = 1'b0;
    add_word(8'h60);
    step(1);
    chk("mid_valid", 32'(out_valid), 1);
    chk("mid_data", 32'(out_data), 32'h60);
    chk("mid_last", 32'(out_last), 1);
    rst_n = 1'b0;
    add_word(8'h61);
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
    step(1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_last", 32'(out_last), 0);
    chk("mid_rst_beat", 32'(beat_cnt), 0);
    chk("mid_rst_stall", 32'(stall_cnt), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    add_word(8'h62); add_word(8'h63); add_word(8'h64);
    expect_beat(8'h61, 0); expect_beat(8'h62, 0); expect_beat(8'h63, 0); expect_beat(8'h64, 1);
    step(1);
    chk("resume_data", 32'(out_data), 32'h61);
    step(6);
    chk("resume_beat", 32'(beat_cnt), 4);

    // Stall counter saturation.
    out_ready = 1'b0;
    add_word(8'h70);
    expect_beat(8'h70, 0);
    step(6);
    chk("stall_5", 32'(stall_cnt), 5);
    step(15);
    chk("stall_sat", 32'(stall_cnt), 15);
    chk("stall_beat", 32'(beat_cnt), 4);
    out_ready = 1'b1;
    step(3);
    chk("final_beat", 32'(beat_cnt), 5);
    chk("final_stall", 32'(stall_cnt), 15);
    chk("final_valid", 32'(out_valid), 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
